// File: rtl/alu_slice_sequencer.sv
// alu_slice_sequencer
//
// Computes a full-width ALU operation by passing the operands one SLICE-bit slice at a
// time, LSB first, through a single SLICE-bit lane. The carry is chained between slices.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   start      request, accepted only while ready=1
//   op         000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB, 110/111 illegal
//   a, b       operands, sampled on acceptance
//   ready      high in idle
//   busy       high while slices are being processed
//   done       one-cycle pulse when result/flags are valid
//   result     assembled result, held until the next acceptance
//   carry_out  final carry of ADD/SUB (1 = no borrow for SUB), 0 for other ops
//   zero       result == 0, updated together with result
//
// WIDTH must be a multiple of SLICE, and WIDTH/SLICE must be at least 2.
module alu_slice_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero
);

  localparam int unsigned N    = WIDTH / SLICE;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpOr  = 3'b001;
  localparam logic [2:0] OpXor = 3'b010;
  localparam logic [2:0] OpNor = 3'b011;
  localparam logic [2:0] OpAdd = 3'b100;
  localparam logic [2:0] OpSub = 3'b101;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [2:0]        op_q, op_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              zero_q, zero_d;

  // Slice lane
  logic [SLICE-1:0]  a_s, b_s, b_x, slice_res;
  logic [SLICE:0]    sum;
  logic              slice_carry;
  logic [WIDTH-1:0]  shifted;

  // Operands are shifted right each step, so the current slice is always the low bits.
  assign a_s = a_q[SLICE-1:0];
  assign b_s = b_q[SLICE-1:0];
  assign b_x = (op_q == OpSub) ? ~b_s : b_s;
  assign sum = {1'b0, a_s} + {1'b0, b_x} + {{SLICE{1'b0}}, carry_q};

  always_comb begin
    slice_res   = '0;
    slice_carry = carry_q;
    case (op_q)
      OpAnd: slice_res = a_s & b_s;
      OpOr:  slice_res = a_s | b_s;
      OpXor: slice_res = a_s ^ b_s;
      OpNor: slice_res = ~(a_s | b_s);
      OpAdd, OpSub: begin
        slice_res   = sum[SLICE-1:0];
        slice_carry = sum[SLICE];
      end
      default: begin
        slice_res   = '0;
        slice_carry = 1'b0;
      end
    endcase
  end

  // New slice enters at the MSB end; after N steps the result is fully aligned.
  assign shifted = {slice_res, result_q[WIDTH-1:SLICE]};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    result_d = result_q;
    zero_d   = zero_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          a_d     = a;
          b_d     = b;
          op_d    = op;
          cnt_d   = '0;
          carry_d = (op == OpSub);
        end
      end
      StRun: begin
        a_d      = a_q >> SLICE;
        b_d      = b_q >> SLICE;
        result_d = shifted;
        zero_d   = (shifted == '0);
        carry_d  = slice_carry;
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign ready     = (state_q == StIdle);
  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign result    = result_q;
  assign carry_out = carry_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Directed self-checking bench for alu_slice_sequencer (default WIDTH=32, SLICE=4).
module tb_alu_slice_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry_out;
  logic        zero;

  int n_checks = 0;
  int n_fail   = 0;

  alu_slice_sequencer #(
    .WIDTH (32),
    .SLICE (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Start an op in cycle 0 and follow it to cycle 12. With disturb set, inputs are
  // scrambled and start is pulsed in cycles 3 and 9; both must be ignored.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] er, input logic ec,
                        input logic ez, input bit disturb);
    int          ndone;
    int          dcyc;
    logic [31:0] r;
    logic        c;
    logic        z;
    a = va;
    b = vb;
    op = o;
    start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    dcyc  = 0;
    r = '0;
    c = 1'b0;
    z = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (cyc == 1) begin
        check_eq({tag, ":busy_c1"}, {31'b0, busy}, 32'd1);
        check_eq({tag, ":ready_c1"}, {31'b0, ready}, 32'd0);
      end
      if (done) begin
        ndone++;
        if (dcyc == 0) begin
          dcyc = cyc;
          r = result;
          c = carry_out;
          z = zero;
        end
      end
      if (cyc == 10) check_eq({tag, ":ready_c10"}, {31'b0, ready}, 32'd1);
      if (disturb && (cyc == 3 || cyc == 9)) begin
        a = 32'hDEAD_BEEF ^ $urandom;
        b = $urandom;
        op = 3'b100;
        start = 1'b1;
        tick();
        start = 1'b0;
      end else begin
        tick();
      end
    end
    check_eq({tag, ":done_count"}, ndone, 32'd1);
    check_eq({tag, ":done_cycle"}, dcyc, 32'd9);
    check_eq({tag, ":result"}, r, er);
    check_eq({tag, ":carry_out"}, {31'b0, c}, {31'b0, ec});
    check_eq({tag, ":zero"}, {31'b0, z}, {31'b0, ez});
    check_eq({tag, ":idle_after"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int ndone;
    int dc [3];
    rst = 1'b1;
    start = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check_eq("rst:ready", {31'b0, ready}, 32'd1);
    check_eq("rst:busy", {31'b0, busy}, 32'd0);
    check_eq("rst:done", {31'b0, done}, 32'd0);
    check_eq("rst:result", result, 32'h0);
    check_eq("rst:carry_out", {31'b0, carry_out}, 32'd0);
    check_eq("rst:zero", {31'b0, zero}, 32'd0);

    run_op("and",      3'b000, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'h0505_0505, 1'b0, 1'b0, 1'b0);
    run_op("or",       3'b001, 32'h0F00_00F0, 32'h00F0_0F00, 32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0);
    run_op("add_wrap", 3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    run_op("add_chain",3'b100, 32'h0000_000F, 32'h0000_0001, 32'h0000_0010, 1'b0, 1'b0, 1'b0);
    run_op("sub_neg",  3'b101, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_op("sub_pos",  3'b101, 32'd7,         32'd5,         32'h0000_0002, 1'b1, 1'b0, 1'b0);
    run_op("xor_eq",   3'b010, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    run_op("nor_zero", 3'b011, 32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    run_op("illegal",  3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    run_op("disturb",  3'b101, 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b1, 1'b0, 1'b1);

    // Start held high: accepted at the end of cycles 0, 10, 20 -> done in 9, 19, 29.
    a = 32'hFFFF_0000;
    b = 32'h0FF0_0FF0;
    op = 3'b000;
    start = 1'b1;
    tick();
    ndone = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (done) begin
        if (ndone < 3) dc[ndone] = cyc;
        ndone++;
        check_eq("held:result", result, 32'h0FF0_0000);
      end
      tick();
    end
    start = 1'b0;
    check_eq("held:done_count", ndone, 32'd3);
    check_eq("held:done0", dc[0], 32'd9);
    check_eq("held:done1", dc[1], 32'd19);
    check_eq("held:done2", dc[2], 32'd29);
    repeat (12) tick();

    // Reset asserted in cycle 4 of an ADD.
    a = 32'h1234_5678;
    b = 32'h1111_1111;
    op = 3'b100;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort:ready", {31'b0, ready}, 32'd1);
    check_eq("abort:busy", {31'b0, busy}, 32'd0);
    check_eq("abort:result", result, 32'h0);
    check_eq("abort:carry_out", {31'b0, carry_out}, 32'd0);
    ndone = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (done) ndone++;
      tick();
    end
    check_eq("abort:no_done", ndone, 32'd0);

    // rst and start on the same edge: not accepted.
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;
    op = 3'b000;
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    check_eq("rst_start:ready", {31'b0, ready}, 32'd1);
    check_eq("rst_start:busy", {31'b0, busy}, 32'd0);
    ndone = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (done || busy) ndone++;
      tick();
    end
    check_eq("rst_start:no_op", ndone, 32'd0);
    check_eq("rst_start:result", result, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
